// File: rtl/eh2_pkg.sv
// Shared types for the LSU ECC correction controller: core config, FSM states, queue entry.
package eh2_pkg;

  localparam int unsigned EH2_DCCM_BITS       = 16;
  localparam int unsigned EH2_DCCM_DATA_WIDTH = 32;

  typedef struct packed {
    int unsigned DCCM_BITS;
    int unsigned DCCM_DATA_WIDTH;
    bit          DCCM_ENABLE;
  } eh2_param_t;

  localparam eh2_param_t EH2_PARAM_DEFAULT = '{
    DCCM_BITS:       EH2_DCCM_BITS,
    DCCM_DATA_WIDTH: EH2_DCCM_DATA_WIDTH,
    DCCM_ENABLE:     1'b1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } corr_state_e;

  typedef struct packed {
    logic [EH2_DCCM_BITS-1:0]       addr;
    logic [EH2_DCCM_DATA_WIDTH-1:0] data;
  } corr_entry_t;

endpackage

// File: rtl/eh2_lsu_ecc_corr_ctl_if.sv
// LSU-side signal bundle of the ECC correction controller.
interface eh2_lsu_ecc_corr_ctl_if;

  logic                                    ld_single_ecc_error_dc5;
  logic                                    ecc_err_lo_dc5;
  logic                                    ecc_err_hi_dc5;
  logic [eh2_pkg::EH2_DCCM_BITS-1:0]       addr_lo_dc5;
  logic [eh2_pkg::EH2_DCCM_BITS-1:0]       addr_hi_dc5;
  logic [eh2_pkg::EH2_DCCM_DATA_WIDTH-1:0] sec_data_lo_dc5;
  logic [eh2_pkg::EH2_DCCM_DATA_WIDTH-1:0] sec_data_hi_dc5;
  logic                                    dec_tlu_core_ecc_disable;
  logic                                    dma_dccm_wen;
  logic                                    stbuf_wen_req;
  logic                                    stbuf_wen_gnt;
  logic                                    corr_wen;
  logic [eh2_pkg::EH2_DCCM_BITS-1:0]       corr_waddr;
  logic [eh2_pkg::EH2_DCCM_DATA_WIDTH-1:0] corr_wdata;
  logic                                    corr_busy;
  logic                                    corr_full;
  logic                                    corr_overflow;

  // LSU pipeline side
  modport master (
    output ld_single_ecc_error_dc5, ecc_err_lo_dc5, ecc_err_hi_dc5,
    output addr_lo_dc5, addr_hi_dc5, sec_data_lo_dc5, sec_data_hi_dc5,
    output dec_tlu_core_ecc_disable, dma_dccm_wen, stbuf_wen_req,
    input  stbuf_wen_gnt, corr_wen, corr_waddr, corr_wdata,
    input  corr_busy, corr_full, corr_overflow
  );

  // Correction controller side
  modport slave (
    input  ld_single_ecc_error_dc5, ecc_err_lo_dc5, ecc_err_hi_dc5,
    input  addr_lo_dc5, addr_hi_dc5, sec_data_lo_dc5, sec_data_hi_dc5,
    input  dec_tlu_core_ecc_disable, dma_dccm_wen, stbuf_wen_req,
    output stbuf_wen_gnt, corr_wen, corr_waddr, corr_wdata,
    output corr_busy, corr_full, corr_overflow
  );

endinterface

// File: rtl/eh2_lsu_ecc_corr_fifo.sv
// Correction queue: two ordered write ports (port 0 lands first), one head read/pop port.
module eh2_lsu_ecc_corr_fifo
  import eh2_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          i_wen0,
  input  corr_entry_t   i_wdata0,
  input  logic          i_wen1,
  input  corr_entry_t   i_wdata1,
  input  logic          i_pop,
  output corr_entry_t   o_head_c,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  corr_entry_t   r_mem [DEPTH];

  logic [PW-1:0] w_wr_ptr1;
  logic [1:0]    w_nwr;

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_nwr     = 2'(i_wen0) + 2'(i_wen1);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Entry storage; contents are don't-care while their slot is free
  always_ff @(posedge clk) begin
    if (i_wen0) r_mem[r_wr_ptr]  <= i_wdata0;
    if (i_wen1) r_mem[w_wr_ptr1] <= i_wdata1;
  end

  // Pointers and occupancy, wrapping modulo DEPTH
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_nwr);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= r_count + CW'(w_nwr) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/eh2_lsu_ecc_corr_ctl.sv
// Queues single-bit ECC corrections from loads and arbitrates the DCCM write port
// between DMA, correction write-back and the store buffer with anti-starvation.
module eh2_lsu_ecc_corr_ctl
  import eh2_pkg::*;
#(
  parameter eh2_param_t  pt         = EH2_PARAM_DEFAULT,
  parameter int unsigned CORR_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                   clk,
  input logic                   rst_l,
  eh2_lsu_ecc_corr_ctl_if.slave bus
);

  localparam int unsigned CW = $clog2(CORR_DEPTH) + 1;
  localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam bit          EN = pt.DCCM_ENABLE;

  corr_state_e   r_state;
  corr_state_e   w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;
  logic          r_overflow;

  corr_entry_t   w_lo_entry;
  corr_entry_t   w_hi_entry;
  corr_entry_t   w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ_nxt;
  logic [1:0]    w_npush;
  logic          w_busy;
  logic          w_full;
  logic          w_event;
  logic          w_drop;
  logic          w_push_lo;
  logic          w_push_hi;
  logic          w_force;
  logic          w_corr_wen;
  logic          w_stbuf_gnt;

  assign w_lo_entry = '{addr: bus.addr_lo_dc5, data: bus.sec_data_lo_dc5};
  assign w_hi_entry = '{addr: bus.addr_hi_dc5, data: bus.sec_data_hi_dc5};

  // Event acceptance: whole event is dropped when fewer than two slots are free
  assign w_busy    = EN && (w_count != '0);
  assign w_full    = EN && (w_count > CW'(CORR_DEPTH - 2));
  assign w_event   = EN && bus.ld_single_ecc_error_dc5 && !bus.dec_tlu_core_ecc_disable;
  assign w_drop    = w_event && w_full;
  assign w_push_lo = w_event && !w_full && bus.ecc_err_lo_dc5;
  assign w_push_hi = w_event && !w_full && bus.ecc_err_hi_dc5;
  assign w_npush   = 2'(w_push_lo) + 2'(w_push_hi);

  // Write-port arbitration: DMA, then forced/idle-port correction, then store buffer
  assign w_force     = (r_state == ST_FORCE);
  assign w_corr_wen  = !bus.dma_dccm_wen && w_busy && (!bus.stbuf_wen_req || w_force);
  assign w_stbuf_gnt = bus.stbuf_wen_req && !bus.dma_dccm_wen && !w_corr_wen;
  assign w_occ_nxt   = w_count + CW'(w_npush) - CW'(w_corr_wen);

  eh2_lsu_ecc_corr_fifo #(
    .DEPTH (CORR_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .i_wen0   (w_push_lo || w_push_hi),
    .i_wdata0 (w_push_lo ? w_lo_entry : w_hi_entry),
    .i_wen1   (w_push_lo && w_push_hi),
    .i_wdata1 (w_hi_entry),
    .i_pop    (w_corr_wen),
    .o_head_c (w_head),
    .o_count  (w_count)
  );

  // Starvation counter: counts store-buffer wins over a pending correction
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_corr_wen) begin
      w_starve_nxt = '0;
    end else if (w_stbuf_gnt && w_busy && (r_starve_cnt != SW'(STARVE_MAX))) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_npush != 2'd0) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_stbuf_gnt && w_busy && (w_starve_nxt == SW'(STARVE_MAX))) begin
          w_state_nxt = ST_FORCE;
        end else if (w_occ_nxt == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FORCE: begin
        if (w_corr_wen) w_state_nxt = (w_occ_nxt == '0) ? ST_IDLE : ST_PEND;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, starvation count and sticky overflow
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_overflow   <= r_overflow || w_drop;
    end
  end

  assign bus.stbuf_wen_gnt = w_stbuf_gnt;
  assign bus.corr_wen      = w_corr_wen;
  assign bus.corr_waddr    = w_busy ? w_head.addr : '0;
  assign bus.corr_wdata    = w_busy ? w_head.data : '0;
  assign bus.corr_busy     = w_busy;
  assign bus.corr_full     = w_full;
  assign bus.corr_overflow = r_overflow;

endmodule

// File: tb/tb_eh2_lsu_ecc_corr_ctl.sv
// Directed bench for the LSU ECC correction controller.
module tb_eh2_lsu_ecc_corr_ctl;
  import eh2_pkg::*;

  logic clk;
  logic rst_l;
  int   checks;
  int   errors;

  eh2_lsu_ecc_corr_ctl_if bus ();

  eh2_lsu_ecc_corr_ctl #(
    .pt         (EH2_PARAM_DEFAULT),
    .CORR_DEPTH (4),
    .STARVE_MAX (3)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_in();
    bus.ld_single_ecc_error_dc5  = 1'b0;
    bus.ecc_err_lo_dc5           = 1'b0;
    bus.ecc_err_hi_dc5           = 1'b0;
    bus.addr_lo_dc5              = '0;
    bus.addr_hi_dc5              = '0;
    bus.sec_data_lo_dc5          = '0;
    bus.sec_data_hi_dc5          = '0;
    bus.dec_tlu_core_ecc_disable = 1'b0;
    bus.dma_dccm_wen             = 1'b0;
    bus.stbuf_wen_req            = 1'b0;
  endtask

  task automatic ev(input logic lo, input logic hi, input logic [15:0] alo, input logic [31:0] dlo,
                    input logic [15:0] ahi, input logic [31:0] dhi);
    bus.ld_single_ecc_error_dc5 = 1'b1;
    bus.ecc_err_lo_dc5  = lo;
    bus.ecc_err_hi_dc5  = hi;
    bus.addr_lo_dc5     = alo;
    bus.sec_data_lo_dc5 = dlo;
    bus.addr_hi_dc5     = ahi;
    bus.sec_data_hi_dc5 = dhi;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    clr_in();
    bus.stbuf_wen_req = 1'b1;
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b exp 0", bus.corr_wen); end
    checks++; if (bus.corr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.corr_busy); end
    checks++; if (bus.corr_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", bus.corr_full); end
    checks++; if (bus.corr_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", bus.corr_overflow); end
    checks++; if (bus.stbuf_wen_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b exp 1", bus.stbuf_wen_gnt); end
    cyc();
    rst_l = 1'b1;
    clr_in();
    cyc();
  endtask

  task automatic test_lo_only();
    ev(1'b1, 1'b0, 16'h0040, 32'hDEADBEEF, 16'h0000, 32'h0);
    #1;
    checks++; if (bus.corr_wen !== 1'b0) begin errors++; $display("FAIL lo_lat: got %b exp 0", bus.corr_wen); end
    cyc(); clr_in(); #1;
    checks++; if (bus.corr_wen !== 1'b1) begin errors++; $display("FAIL lo_wen: got %b exp 1", bus.corr_wen); end
    checks++; if (bus.corr_waddr !== 16'h0040) begin errors++; $display("FAIL lo_addr: got %h exp 0040", bus.corr_waddr); end
    checks++; if (bus.corr_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lo_data: got %h exp deadbeef", bus.corr_wdata); end
    checks++; if (dut.r_state !== ST_PEND) begin errors++; $display("FAIL lo_pend: got %0d exp %0d", dut.r_state, ST_PEND); end
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b0 || bus.corr_busy !== 1'b0) begin errors++; $display("FAIL lo_drain: got wen=%b busy=%b exp 0/0", bus.corr_wen, bus.corr_busy); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL lo_idle: got %0d exp %0d", dut.r_state, ST_IDLE); end
  endtask

  task automatic test_dual();
    ev(1'b1, 1'b1, 16'h0044, 32'h11110044, 16'h0048, 32'h22220048);
    cyc(); clr_in(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0044 || bus.corr_wdata !== 32'h11110044) begin errors++; $display("FAIL dual_first: got wen=%b %h/%h exp 1 0044/11110044", bus.corr_wen, bus.corr_waddr, bus.corr_wdata); end
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0048 || bus.corr_wdata !== 32'h22220048) begin errors++; $display("FAIL dual_second: got wen=%b %h/%h exp 1 0048/22220048", bus.corr_wen, bus.corr_waddr, bus.corr_wdata); end
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0) begin errors++; $display("FAIL dual_empty: got %b exp 0", bus.corr_busy); end
  endtask

  task automatic test_back_to_back();
    ev(1'b1, 1'b0, 16'h00A0, 32'hA0A0A0A0, 16'h0, 32'h0);
    cyc();
    ev(1'b1, 1'b0, 16'h00A4, 32'hA4A4A4A4, 16'h0, 32'h0);
    #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h00A0) begin errors++; $display("FAIL b2b_first: got wen=%b %h exp 1 00a0", bus.corr_wen, bus.corr_waddr); end
    cyc(); clr_in(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_wdata !== 32'hA4A4A4A4) begin errors++; $display("FAIL b2b_second: got wen=%b %h exp 1 a4a4a4a4", bus.corr_wen, bus.corr_wdata); end
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0 || dut.r_state !== ST_IDLE) begin errors++; $display("FAIL b2b_empty: got busy=%b st=%0d exp 0/0", bus.corr_busy, dut.r_state); end
  endtask

  task automatic test_starve();
    ev(1'b1, 1'b0, 16'h0050, 32'h55555555, 16'h0, 32'h0);
    bus.stbuf_wen_req = 1'b1;
    cyc();
    bus.ld_single_ecc_error_dc5 = 1'b0;
    bus.ecc_err_lo_dc5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.stbuf_wen_gnt !== 1'b1 || bus.corr_wen !== 1'b0) begin errors++; $display("FAIL starve_gnt%0d: got gnt=%b wen=%b exp 1/0", i, bus.stbuf_wen_gnt, bus.corr_wen); end
      checks++; if (dut.r_starve_cnt !== 2'(i)) begin errors++; $display("FAIL starve_cnt%0d: got %0d exp %0d", i, dut.r_starve_cnt, i); end
      cyc();
    end
    #1;
    checks++; if (dut.r_state !== ST_FORCE) begin errors++; $display("FAIL starve_force: got %0d exp %0d", dut.r_state, ST_FORCE); end
    checks++; if (bus.corr_wen !== 1'b1 || bus.stbuf_wen_gnt !== 1'b0 || bus.corr_waddr !== 16'h0050) begin errors++; $display("FAIL starve_corr: got wen=%b gnt=%b %h exp 1/0 0050", bus.corr_wen, bus.stbuf_wen_gnt, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.stbuf_wen_gnt !== 1'b1 || bus.corr_wen !== 1'b0 || dut.r_state !== ST_IDLE) begin errors++; $display("FAIL starve_resume: got gnt=%b wen=%b st=%0d exp 1/0/0", bus.stbuf_wen_gnt, bus.corr_wen, dut.r_state); end
    clr_in();
    cyc();
  endtask

  task automatic test_dma();
    ev(1'b1, 1'b1, 16'h0060, 32'h60606060, 16'h0064, 32'h64646464);
    bus.stbuf_wen_req = 1'b1;
    cyc();
    bus.ld_single_ecc_error_dc5 = 1'b0;
    cyc();
    bus.dma_dccm_wen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.corr_wen !== 1'b0 || bus.stbuf_wen_gnt !== 1'b0) begin errors++; $display("FAIL dma_block%0d: got wen=%b gnt=%b exp 0/0", i, bus.corr_wen, bus.stbuf_wen_gnt); end
      checks++; if (dut.r_starve_cnt !== 2'd1) begin errors++; $display("FAIL dma_starve%0d: got %0d exp 1", i, dut.r_starve_cnt); end
      cyc();
    end
    clr_in(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0060) begin errors++; $display("FAIL dma_drain0: got wen=%b %h exp 1 0060", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0064) begin errors++; $display("FAIL dma_drain1: got wen=%b %h exp 1 0064", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0 || dut.r_starve_cnt !== 2'd0) begin errors++; $display("FAIL dma_done: got busy=%b cnt=%0d exp 0/0", bus.corr_busy, dut.r_starve_cnt); end
  endtask

  task automatic test_ecc_disable();
    bus.dma_dccm_wen = 1'b1;
    ev(1'b1, 1'b0, 16'h0090, 32'h90909090, 16'h0, 32'h0);
    cyc();
    ev(1'b1, 1'b0, 16'h0094, 32'h94949494, 16'h0, 32'h0);
    bus.dec_tlu_core_ecc_disable = 1'b1;
    cyc();
    bus.ld_single_ecc_error_dc5 = 1'b0;
    bus.dma_dccm_wen = 1'b0;
    #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0090) begin errors++; $display("FAIL dis_drain: got wen=%b %h exp 1 0090", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0 || bus.corr_overflow !== 1'b0) begin errors++; $display("FAIL dis_nopush: got busy=%b ovf=%b exp 0/0", bus.corr_busy, bus.corr_overflow); end
    clr_in();
  endtask

  task automatic test_overflow();
    bus.dma_dccm_wen = 1'b1;
    ev(1'b1, 1'b1, 16'h0070, 32'h70707070, 16'h0074, 32'h74747474);
    #1;
    checks++; if (bus.corr_full !== 1'b0) begin errors++; $display("FAIL ovf_full0: got %b exp 0", bus.corr_full); end
    cyc();
    ev(1'b1, 1'b0, 16'h0078, 32'h78787878, 16'h0, 32'h0);
    #1;
    checks++; if (bus.corr_full !== 1'b0) begin errors++; $display("FAIL ovf_full2: got %b exp 0", bus.corr_full); end
    cyc();
    ev(1'b1, 1'b1, 16'h007C, 32'h7C7C7C7C, 16'h0080, 32'h80808080);
    #1;
    checks++; if (bus.corr_full !== 1'b1 || bus.corr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_full3: got full=%b ovf=%b exp 1/0", bus.corr_full, bus.corr_overflow); end
    cyc(); clr_in(); #1;
    checks++; if (bus.corr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", bus.corr_overflow); end
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0070) begin errors++; $display("FAIL ovf_d0: got wen=%b %h exp 1 0070", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0074) begin errors++; $display("FAIL ovf_d1: got wen=%b %h exp 1 0074", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h0078) begin errors++; $display("FAIL ovf_d2: got wen=%b %h exp 1 0078", bus.corr_wen, bus.corr_waddr); end
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0 || bus.corr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_whole_drop: got busy=%b ovf=%b exp 0/1", bus.corr_busy, bus.corr_overflow); end
    ev(1'b1, 1'b1, 16'h00B0, 32'hB0B0B0B0, 16'h00B4, 32'hB4B4B4B4);
    cyc(); clr_in(); #1;
    checks++; if (bus.corr_wen !== 1'b1 || bus.corr_waddr !== 16'h00B0) begin errors++; $display("FAIL rst_mid_d0: got wen=%b %h exp 1 00b0", bus.corr_wen, bus.corr_waddr); end
    cyc();
    rst_l = 1'b0;
    #1;
    checks++; if (bus.corr_wen !== 1'b0 || bus.corr_busy !== 1'b0 || bus.corr_full !== 1'b0 || bus.corr_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got wen=%b busy=%b full=%b ovf=%b exp 0000", bus.corr_wen, bus.corr_busy, bus.corr_full, bus.corr_overflow); end
    checks++; if (bus.corr_waddr !== 16'h0 || bus.corr_wdata !== 32'h0 || bus.stbuf_wen_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_bus: got %h/%h gnt=%b exp 0/0/0", bus.corr_waddr, bus.corr_wdata, bus.stbuf_wen_gnt); end
    cyc();
    rst_l = 1'b1;
    cyc(); #1;
    checks++; if (bus.corr_busy !== 1'b0 || bus.corr_wen !== 1'b0 || dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rst_mid_after: got busy=%b wen=%b st=%0d exp 0/0/0", bus.corr_busy, bus.corr_wen, dut.r_state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lo_only();
    cyc();
    test_dual();
    cyc();
    test_back_to_back();
    cyc();
    test_starve();
    test_dma();
    cyc();
    test_ecc_disable();
    cyc();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
